pe_issue_ctrl: RTL and testbench

Per-PE control stage that sits directly upstream of `data_mem` and drives all of its control and write-data inputs. It does three things:
- registers the incoming load/shift/tx data stream onto `wea`/`web`/`wec`/`dina`;
- holds a small instruction store and issues it as `inst_v`/`inst`;
- asserts `wed` a fixed number of cycles after each issued instruction, so results land at the destination address carried by that instruction.

Loads and instruction execution never overlap. This keeps the `wea`-over-`wed` priority inside `data_mem` from ever dropping a write-back.

---
 rtl/pe_issue_ctrl_if.sv | 34 +++
 rtl/pe_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_pe_issue_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pe_issue_ctrl_if.sv
// pe_issue_ctrl_if: stream, instruction-store, command and data_mem control bundle for pe_issue_ctrl
interface pe_issue_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int INST_WIDTH = 32,
  parameter int IM_ADDR_WIDTH = 4
);
  logic din_v;
  logic din_rdy;
  logic [DATA_WIDTH*2-1:0] din;
  logic [1:0] din_type;
  logic imem_we;
  logic [IM_ADDR_WIDTH-1:0] imem_addr;
  logic [INST_WIDTH-1:0] imem_din;
  logic start;
  logic [IM_ADDR_WIDTH:0] inst_num;
  logic shift_start;
  logic [7:0] shift_len;
  logic wea, web, wec, wed;
  logic [DATA_WIDTH*2-1:0] dina;
  logic rden;
  logic inst_v;
  logic [INST_WIDTH-1:0] inst;
  logic shift_v;
  logic busy;
  logic done;
  modport master (
    output din_v, din, din_type, imem_we, imem_addr, imem_din, start, inst_num, shift_start, shift_len,
    input din_rdy, wea, web, wec, wed, dina, rden, inst_v, inst, shift_v, busy, done
  );
  modport slave (
    input din_v, din, din_type, imem_we, imem_addr, imem_din, start, inst_num, shift_start, shift_len,
    output din_rdy, wea, web, wec, wed, dina, rden, inst_v, inst, shift_v, busy, done
  );
endinterface

// File: rtl/pe_issue_ctrl.sv
// pe_issue_ctrl: registers load/shift/tx writes into data_mem, issues the stored program and
// times the matching write-back strobes; loads are only accepted while idle so they never meet wed.
module pe_issue_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int INST_WIDTH = 32,
  parameter int IM_ADDR_WIDTH = 4,
  parameter int WB_LAT = 6
) (
  input logic clk,
  input logic rst,
  pe_issue_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** IM_ADDR_WIDTH;
  localparam int NW = IM_ADDR_WIDTH + 1;
  localparam int CW = NW > 8 ? NW : 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, SHIFT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IM_ADDR_WIDTH-1:0] pc, pc_n;
  logic inst_v, inst_v_n, shift_v, shift_v_n, done, done_n;
  logic [INST_WIDTH-1:0] inst, inst_n;
  logic [WB_LAT-1:0] wb, wb_nxt;
  logic [INST_WIDTH-1:0] imem [DEPTH];
  logic [NW-1:0] n_clamp;
  logic acc;
  logic wea, web, wec;
  logic [DATA_WIDTH*2-1:0] dina;
  assign n_clamp = bus.inst_num > NW'(DEPTH) ? NW'(DEPTH) : bus.inst_num;
  assign wb_nxt = WB_LAT'({wb, inst_v});
  assign bus.din_rdy = (state == IDLE) & ~rst;
  assign acc = bus.din_v & bus.din_rdy;
  assign bus.busy = state != IDLE;
  assign bus.rden = state != IDLE;
  assign bus.inst_v = inst_v;
  assign bus.inst = inst;
  assign bus.shift_v = shift_v;
  assign bus.done = done;
  assign bus.wed = wb[WB_LAT-1];
  assign bus.wea = wea;
  assign bus.web = web;
  assign bus.wec = wec;
  assign bus.dina = dina;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pc <= '0;
      inst_v <= 1'b0;
      inst <= '0;
      shift_v <= 1'b0;
      done <= 1'b0;
      wb <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pc <= pc_n;
      inst_v <= inst_v_n;
      inst <= inst_n;
      shift_v <= shift_v_n;
      done <= done_n;
      wb <= wb_nxt;
    end
  end
  // cnt holds the issues/shifts still owed after the one being registered this cycle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pc_n = pc;
    inst_v_n = 1'b0;
    inst_n = inst;
    shift_v_n = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (n_clamp == '0) done_n = 1'b1;
          else begin
            state_n = RUN;
            inst_v_n = 1'b1;
            inst_n = imem[0];
            pc_n = IM_ADDR_WIDTH'(1);
            cnt_n = CW'(n_clamp) - 1'b1;
          end
        end else if (bus.shift_start) begin
          if (bus.shift_len == '0) done_n = 1'b1;
          else begin
            state_n = SHIFT;
            shift_v_n = 1'b1;
            cnt_n = CW'(bus.shift_len) - 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt != '0) begin
          inst_v_n = 1'b1;
          inst_n = imem[pc];
          pc_n = pc + 1'b1;
          cnt_n = cnt - 1'b1;
        end else state_n = DRAIN;
      end
      DRAIN: begin
        state_n = wb_nxt == '0 ? IDLE : DRAIN;
        done_n = wb_nxt == '0;
      end
      SHIFT: begin
        if (cnt != '0) begin
          shift_v_n = 1'b1;
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = IDLE;
          done_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wea <= 1'b0;
      web <= 1'b0;
      wec <= 1'b0;
      dina <= '0;
    end else begin
      wea <= acc & (bus.din_type == 2'd0);
      web <= acc & (bus.din_type == 2'd1);
      wec <= acc & (bus.din_type == 2'd2);
      dina <= acc && bus.din_type != 2'd3 ? bus.din : dina;
    end
  end
  // program store survives reset, so it lives outside the reset domain
  always_ff @(posedge clk) begin
    if (bus.imem_we && state == IDLE && !rst) imem[bus.imem_addr] <= bus.imem_din;
  end
endmodule

// File: tb/tb_pe_issue_ctrl.sv
// tb_pe_issue_ctrl: directed stimulus pushes expected pulses into a scoreboard; a negedge monitor matches them.
module tb_pe_issue_ctrl;
  localparam int WB = 6;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mem [16];
  typedef struct {int k; int c; logic [31:0] d;} ev_t;
  ev_t sb[$];
  string nm [7] = '{"wea", "web", "wec", "inst_v", "wed", "shift_v", "done"};
  pe_issue_ctrl_if #(.DATA_WIDTH(16), .INST_WIDTH(32), .IM_ADDR_WIDTH(4)) io ();
  pe_issue_ctrl #(.DATA_WIDTH(16), .INST_WIDTH(32), .IM_ADDR_WIDTH(4), .WB_LAT(WB)) dut (
    .clk(clk), .rst(rst), .bus(io)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int k, input int c, input logic [31:0] d);
    ev_t e;
    e.k = k;
    e.c = c;
    e.d = d;
    sb.push_back(e);
  endtask
  task automatic obs(input int k, input logic [31:0] d);
    int idx = -1;
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].k == k && sb[i].c == cyc) begin
        idx = i;
        break;
      end
    n_vec++;
    if (idx < 0) begin
      n_err++;
      $display("FAIL %s: unexpected pulse at cycle %0d (none expected)", nm[k], cyc);
    end else begin
      if (sb[idx].d !== d) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %h, expected %h", nm[k], cyc, d, sb[idx].d);
      end
      sb.delete(idx);
    end
  endtask
  task automatic sweep(input int lim);
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].c <= lim) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: expected pulse at cycle %0d not seen (got none)", nm[sb[i].k], sb[i].c);
        sb.delete(i);
      end
  endtask
  always @(negedge clk) begin
    if (io.wea) obs(0, io.dina);
    if (io.web) obs(1, io.dina);
    if (io.wec) obs(2, io.dina);
    if (io.inst_v) obs(3, io.inst);
    if (io.wed) obs(4, 32'h0);
    if (io.shift_v) obs(5, 32'h0);
    if (io.done) obs(6, 32'h0);
    sweep(cyc);
  end
  task automatic chk(input string s, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h, expected %h", s, cyc, act, exp);
    end
  endtask
  task automatic chk_zero(input string s);
    chk({s, " din_rdy"}, 32'(io.din_rdy), 0);
    chk({s, " busy"}, 32'(io.busy), 0);
    chk({s, " done"}, 32'(io.done), 0);
    chk({s, " dina"}, io.dina, 0);
    chk({s, " inst"}, io.inst, 0);
    chk({s, " strobes"}, 32'({io.wea, io.web, io.wec, io.wed, io.inst_v, io.shift_v, io.rden}), 0);
  endtask
  task automatic wr(input int a, input logic [31:0] d);
    io.imem_we = 1'b1;
    io.imem_addr = 4'(a);
    io.imem_din = d;
    mem[a] = d;
    tick();
    io.imem_we = 1'b0;
  endtask
  task automatic start_prog(input int n, input bit also_shift);
    int nn = n > 16 ? 16 : n;
    int p = cyc;
    io.start = 1'b1;
    io.inst_num = 5'(n);
    io.shift_start = also_shift;
    io.shift_len = 8'd5;
    for (int i = 0; i < nn; i++) begin
      push(3, p + 1 + i, mem[i]);
      push(4, p + 1 + i + WB, 32'h0);
    end
    push(6, nn == 0 ? p + 1 : p + nn + WB + 1, 32'h0);
    tick();
    io.start = 1'b0;
    io.shift_start = 1'b0;
  endtask
  task automatic start_shift(input int l);
    int p = cyc;
    io.shift_start = 1'b1;
    io.shift_len = 8'(l);
    for (int i = 0; i < l; i++) push(5, p + 1 + i, 32'h0);
    push(6, p + l + 1, 32'h0);
    tick();
    io.shift_start = 1'b0;
    repeat (l + 2) tick();
  endtask
  initial begin
    int p;
    io.din_v = 0; io.din = 0; io.din_type = 0; io.imem_we = 0; io.imem_addr = 0; io.imem_din = 0;
    io.start = 0; io.inst_num = 0; io.shift_start = 0; io.shift_len = 0;
    #1 rst = 1'b1;
    #2 chk_zero("reset");
    repeat (2) tick();
    chk_zero("reset held");
    rst = 1'b0;
    tick();
    chk("idle din_rdy", 32'(io.din_rdy), 1);
    chk("idle busy", 32'(io.busy), 0);
    p = cyc;
    io.din_v = 1'b1;
    io.din_type = 2'd0; io.din = 32'h00010002; push(0, p + 1, 32'h00010002); tick();
    io.din_type = 2'd1; io.din = 32'h00030004; push(1, p + 2, 32'h00030004); tick();
    io.din_type = 2'd2; io.din = 32'h00050006; push(2, p + 3, 32'h00050006); tick();
    io.din_type = 2'd3; io.din = 32'h00070008; tick();
    io.din_v = 1'b0;
    repeat (2) tick();
    chk("dina hold after discard", io.dina, 32'h00050006);
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    wr(0, 32'h00010240); wr(1, 32'h00030441); wr(2, 32'h00050642); wr(3, 32'h00070843);
    start_prog(4, 1'b0);
    chk("run din_rdy", 32'(io.din_rdy), 0);
    chk("run busy", 32'(io.busy), 1);
    chk("run rden", 32'(io.rden), 1);
    repeat (5) tick();
    chk("drain din_rdy", 32'(io.din_rdy), 0);
    repeat (6) tick();
    chk("post-program busy", 32'(io.busy), 0);
    start_shift(32);
    start_shift(0);
    start_prog(0, 1'b0);
    repeat (3) tick();
    start_prog(4, 1'b1);
    io.start = 1'b1; io.inst_num = 5'd2; io.shift_start = 1'b1; io.shift_len = 8'd3;
    io.imem_we = 1'b1; io.imem_addr = 4'd0; io.imem_din = 32'hDEADBEEF;
    tick();
    io.start = 1'b0; io.shift_start = 1'b0; io.imem_we = 1'b0;
    repeat (12) tick();
    start_prog(1, 1'b0);
    repeat (WB + 3) tick();
    for (int i = 4; i < 16; i++) wr(i, 32'h10000000 + 32'(i) * 32'h00010101);
    start_prog(20, 1'b0);
    repeat (16 + WB + 3) tick();
    p = cyc;
    start_prog(4, 1'b0);
    io.din_v = 1'b1; io.din_type = 2'd1; io.din = 32'hABCD1234;
    push(1, p + 12, 32'hABCD1234);
    repeat (9) tick();
    chk("backpressure din_rdy", 32'(io.din_rdy), 0);
    tick();
    chk("release din_rdy", 32'(io.din_rdy), 1);
    tick();
    io.din_v = 1'b0;
    repeat (3) tick();
    p = cyc;
    io.start = 1'b1; io.inst_num = 5'd4;
    push(3, p + 1, mem[0]);
    push(3, p + 2, mem[1]);
    tick();
    io.start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1 chk_zero("mid-run reset");
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    start_prog(4, 1'b0);
    repeat (4 + WB + 3) tick();
    sweep(cyc + 100000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
